// File: rtl/kan_pkg.sv
// Shared definitions for the KAN layer datapath stages (MAC accumulator, clamp).
package kan_pkg;

    // Default headroom kept above the full-precision product width.
    localparam int ACC_GUARD_BITS = 8;

    // Fractional bits of a product/sum of two operands with frac_bits each.
    function automatic int mac_frac_bits(input int frac_bits);
        return 2 * frac_bits;
    endfunction

endpackage

// File: rtl/axis_mac_product.sv
// Registered operand multiplier (stage P): captures a*b on each input handshake
// and holds its contents while the downstream stage signals a stall.
module axis_mac_product
    import kan_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int UNSIGNED_DATA = 0,
    parameter int ID_WIDTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*DATA_WIDTH-1:0] s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    input  logic [ID_WIDTH-1:0]     s_tid,
    input  logic                    stall,
    output logic [2*DATA_WIDTH-1:0] p_data,
    output logic                    p_valid,
    output logic                    p_last,
    output logic [ID_WIDTH-1:0]     p_id
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] product;
    logic          handshake;

    // Extending both operands to the product width lets one PW x PW multiply
    // (truncated to PW bits) serve both signed and unsigned formats.
    always_comb begin
        if (UNSIGNED_DATA != 0) begin
            a_ext = {{DATA_WIDTH{1'b0}}, s_tdata[DATA_WIDTH-1:0]};
            b_ext = {{DATA_WIDTH{1'b0}}, s_tdata[PW-1:DATA_WIDTH]};
        end else begin
            a_ext = {{DATA_WIDTH{s_tdata[DATA_WIDTH-1]}}, s_tdata[DATA_WIDTH-1:0]};
            b_ext = {{DATA_WIDTH{s_tdata[PW-1]}}, s_tdata[PW-1:DATA_WIDTH]};
        end
        product = a_ext * b_ext;
    end

    assign s_tready  = !stall;
    assign handshake = s_tvalid && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_data  <= '0;
            p_last  <= 1'b0;
            p_id    <= '0;
        end else if (!stall) begin
            p_valid <= handshake;
            if (handshake) begin
                p_data <= product;
                p_last <= s_tlast;
                p_id   <= s_tid;
            end
        end
    end

endmodule

// File: rtl/axis_mac_accumulator.sv
// Frame-based AXI-Stream multiply-accumulate: sums a*b over each tlast-delimited
// frame and emits one full-precision result beat per frame with a sticky overflow flag.
module axis_mac_accumulator
    import kan_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int FRACTIONAL_BITS = 8,
    parameter int ACC_WIDTH       = 2 * DATA_WIDTH + ACC_GUARD_BITS,
    parameter int UNSIGNED_DATA   = 0,
    parameter int ID_ENABLE       = 0,
    parameter int ID_WIDTH        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [ID_WIDTH-1:0]     s_axis_tid,
    output logic [ACC_WIDTH-1:0]    m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [ID_WIDTH-1:0]     m_axis_tid,
    output logic                    m_axis_tuser
);

    localparam int PW = 2 * DATA_WIDTH;

    if (ACC_WIDTH < PW) begin : g_acc_width_check
        $error("axis_mac_accumulator: ACC_WIDTH must be >= 2*DATA_WIDTH");
    end
    if (mac_frac_bits(FRACTIONAL_BITS) > ACC_WIDTH) begin : g_frac_check
        $error("axis_mac_accumulator: result fractional bits exceed ACC_WIDTH");
    end

    logic [PW-1:0]        p_data;
    logic                 p_valid;
    logic                 p_last;
    logic [ID_WIDTH-1:0]  p_id;
    logic                 stall;
    logic                 advance;

    logic [ACC_WIDTH-1:0] acc;
    logic                 first;
    logic                 ovf;

    logic [ACC_WIDTH-1:0] p_ext;
    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH:0]   sum_full;
    logic [ACC_WIDTH-1:0] sum;
    logic                 new_ovf;

    // Handshakes: a beat transfers on a rising clk edge where tvalid && tready;
    // a source holds tvalid and payload steady until it transfers. Only a frame's
    // last product can stall, and only while the output register is still full.
    assign stall   = p_valid && p_last && m_axis_tvalid && !m_axis_tready;
    assign advance = p_valid && !stall;

    axis_mac_product #(
        .DATA_WIDTH   (DATA_WIDTH),
        .UNSIGNED_DATA(UNSIGNED_DATA),
        .ID_WIDTH     (ID_WIDTH)
    ) u_product (
        .clk     (clk),
        .rst     (rst),
        .s_tdata (s_axis_tdata),
        .s_tvalid(s_axis_tvalid),
        .s_tready(s_axis_tready),
        .s_tlast (s_axis_tlast),
        .s_tid   (s_axis_tid),
        .stall   (stall),
        .p_data  (p_data),
        .p_valid (p_valid),
        .p_last  (p_last),
        .p_id    (p_id)
    );

    always_comb begin
        if (UNSIGNED_DATA != 0) begin
            p_ext = ACC_WIDTH'(p_data);
        end else begin
            p_ext = ACC_WIDTH'($signed(p_data));
        end
        base     = first ? '0 : acc;
        sum_full = {1'b0, base} + {1'b0, p_ext};
        sum      = sum_full[ACC_WIDTH-1:0];
        // The sum wraps; overflow is only reported, saturation happens downstream.
        if (UNSIGNED_DATA != 0) begin
            new_ovf = sum_full[ACC_WIDTH];
        end else begin
            new_ovf = (base[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
        end
    end

    assign m_axis_tlast = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            first         <= 1'b1;
            ovf           <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tid    <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (advance) begin
                if (p_last) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= sum;
                    m_axis_tuser  <= ovf | new_ovf;
                    m_axis_tid    <= (ID_ENABLE != 0) ? p_id : '0;
                    first         <= 1'b1;
                    ovf           <= 1'b0;
                end else begin
                    acc   <= sum;
                    first <= 1'b0;
                    ovf   <= ovf | new_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_mac_accumulator.sv
// Directed bench for axis_mac_accumulator: three instances (signed/40-bit with ids,
// signed/32-bit, unsigned/40-bit) share one stimulus bus selected by sel.
module tb_axis_mac_accumulator;

    logic        clk;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic [7:0]  s_tid;
    logic        m_tready;
    int          sel;

    logic        tv0, tv1, tv2;
    logic        tr0, tr1, tr2;
    logic [39:0] md0;
    logic [31:0] md1;
    logic [39:0] md2;
    logic        mv0, mv1, mv2;
    logic        ml0, ml1, ml2;
    logic [7:0]  mid0, mid1, mid2;
    logic        mu0, mu1, mu2;

    logic [39:0] v_data;
    logic        v_valid, v_last, v_user, v_tready;
    logic [7:0]  v_id;

    int          checks;
    int          errors;
    int          cyc;
    int          stall_cycles;

    logic [39:0] exp_q[$];
    logic [39:0] got_data[$];
    logic        got_user[$];
    logic [7:0]  got_id[$];
    int          got_cyc[$];

    assign tv0 = s_tvalid && (sel == 0);
    assign tv1 = s_tvalid && (sel == 1);
    assign tv2 = s_tvalid && (sel == 2);

    axis_mac_accumulator #(
        .DATA_WIDTH(16), .FRACTIONAL_BITS(8), .ACC_WIDTH(40),
        .UNSIGNED_DATA(0), .ID_ENABLE(1), .ID_WIDTH(8)
    ) u_sgn (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(tv0), .s_axis_tready(tr0),
        .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .m_axis_tdata(md0), .m_axis_tvalid(mv0), .m_axis_tready(m_tready),
        .m_axis_tlast(ml0), .m_axis_tid(mid0), .m_axis_tuser(mu0)
    );

    axis_mac_accumulator #(
        .DATA_WIDTH(16), .FRACTIONAL_BITS(8), .ACC_WIDTH(32),
        .UNSIGNED_DATA(0), .ID_ENABLE(0), .ID_WIDTH(8)
    ) u_w32 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(tv1), .s_axis_tready(tr1),
        .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .m_axis_tdata(md1), .m_axis_tvalid(mv1), .m_axis_tready(m_tready),
        .m_axis_tlast(ml1), .m_axis_tid(mid1), .m_axis_tuser(mu1)
    );

    axis_mac_accumulator #(
        .DATA_WIDTH(16), .FRACTIONAL_BITS(8), .ACC_WIDTH(40),
        .UNSIGNED_DATA(1), .ID_ENABLE(0), .ID_WIDTH(8)
    ) u_uns (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(tv2), .s_axis_tready(tr2),
        .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .m_axis_tdata(md2), .m_axis_tvalid(mv2), .m_axis_tready(m_tready),
        .m_axis_tlast(ml2), .m_axis_tid(mid2), .m_axis_tuser(mu2)
    );

    always_comb begin
        v_data = md0; v_valid = mv0; v_last = ml0; v_user = mu0; v_id = mid0; v_tready = tr0;
        if (sel == 1) begin
            v_data = {8'h00, md1}; v_valid = mv1; v_last = ml1; v_user = mu1; v_id = mid1; v_tready = tr1;
        end else if (sel == 2) begin
            v_data = md2; v_valid = mv2; v_last = ml2; v_user = mu2; v_id = mid2; v_tready = tr2;
        end
    end

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Output monitor: a result transfers at the next rising edge when seen here.
    always @(negedge clk) begin
        if (v_valid && m_tready) begin
            got_data.push_back(v_data);
            got_user.push_back(v_user);
            got_id.push_back(v_id);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d results", got_data.size());
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic clear_queues();
        exp_q.delete();
        got_data.delete();
        got_user.delete();
        got_id.delete();
        got_cyc.delete();
        stall_cycles = 0;
    endtask

    task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                             input logic last, input logic [7:0] id);
        logic ok;
        logic done;
        done     = 1'b0;
        s_tdata  = {b, a};
        s_tlast  = last;
        s_tid    = id;
        s_tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = v_tready;
            @(posedge clk);
            #1;
            if (ok) begin
                done = 1'b1;
                break;
            end
            stall_cycles++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_beat_timeout: beat a=%h b=%h not accepted in 50 cycles, required accepted", a, b);
        end
    endtask

    task automatic wait_results(input int n, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (got_data.size() >= n) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        sel = 0;
        checks++; if (v_valid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", v_valid); end
        checks++; if (v_data !== 40'h0) begin errors++; $display("FAIL reset_tdata: got %h want 0", v_data); end
        checks++; if (v_user !== 1'b0) begin errors++; $display("FAIL reset_tuser: got %b want 0", v_user); end
        checks++; if (v_id !== 8'h00) begin errors++; $display("FAIL reset_tid: got %h want 00", v_id); end
        checks++; if (v_last !== 1'b1) begin errors++; $display("FAIL reset_tlast: got %b want 1", v_last); end
        checks++; if (v_tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready: got %b want 1", v_tready); end
        checks++; if (mv1 !== 1'b0 || mv2 !== 1'b0) begin errors++; $display("FAIL reset_other_tvalid: got %b%b want 00", mv1, mv2); end
    endtask

    task automatic test_frame_sum();
        int acc_cyc;
        clear_queues();
        sel = 0;
        m_tready = 1'b1;
        // 4 x (1.0 * 2.0) = 8.0 with 16 fractional bits
        exp_q.push_back(40'h00_0008_0000);
        for (int i = 0; i < 4; i++) send_beat(16'h0100, 16'h0200, (i == 3), 8'(i + 1));
        acc_cyc = cyc;
        wait_results(1, 20);
        idle(3);
        checks++; if (got_data.size() != 1) begin errors++; $display("FAIL frame_count: got %0d results want 1", got_data.size()); end
        if (got_data.size() >= 1) begin
            checks++; if (got_data[0] !== exp_q[0]) begin errors++; $display("FAIL frame_sum: got %h want %h", got_data[0], exp_q[0]); end
            checks++; if (got_user[0] !== 1'b0) begin errors++; $display("FAIL frame_tuser: got %b want 0", got_user[0]); end
            checks++; if (got_id[0] !== 8'h04) begin errors++; $display("FAIL frame_tid: got %h want 04", got_id[0]); end
            // Accepted in the cycle ending at edge acc_cyc; valid two cycles later.
            checks++; if (got_cyc[0] != acc_cyc + 1) begin errors++; $display("FAIL frame_latency: got edge %0d want %0d", got_cyc[0], acc_cyc + 1); end
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        sel = 0;
        m_tready = 1'b1;
        exp_q.push_back(40'hFF_FFFD_0000);
        exp_q.push_back(40'h00_0001_0000);
        send_beat(16'hFF00, 16'h0300, 1'b1, 8'h07);
        send_beat(16'h0100, 16'h0100, 1'b1, 8'h08);
        wait_results(2, 20);
        idle(3);
        checks++; if (got_data.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d results want 2", got_data.size()); end
        checks++; if (stall_cycles != 0) begin errors++; $display("FAIL b2b_throughput: got %0d stall cycles want 0", stall_cycles); end
        if (got_data.size() == 2) begin
            for (int i = 0; i < 2; i++) begin
                checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_sum%0d: got %h want %h", i, got_data[i], exp_q[i]); end
            end
            checks++; if (got_id[1] !== 8'h08) begin errors++; $display("FAIL b2b_tid: got %h want 08", got_id[1]); end
            checks++; if (got_cyc[1] != got_cyc[0] + 1) begin errors++; $display("FAIL b2b_consecutive: got edges %0d,%0d want adjacent", got_cyc[0], got_cyc[1]); end
        end
    endtask

    task automatic test_backpressure();
        clear_queues();
        sel = 0;
        m_tready = 1'b0;
        exp_q.push_back(40'h00_0002_0000);
        exp_q.push_back(40'h00_0005_0000);
        send_beat(16'h0100, 16'h0100, 1'b0, 8'h11);
        send_beat(16'h0100, 16'h0100, 1'b1, 8'h12);
        send_beat(16'h0200, 16'h0100, 1'b0, 8'h21);
        send_beat(16'h0100, 16'h0300, 1'b1, 8'h22);
        checks++; if (stall_cycles != 0) begin errors++; $display("FAIL bp_no_early_stall: got %0d stall cycles want 0", stall_cycles); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (v_tready !== 1'b0) begin errors++; $display("FAIL bp_s_tready_low: cycle %0d got %b want 0", i, v_tready); end
            checks++; if (v_valid !== 1'b1 || v_data !== 40'h00_0002_0000) begin
                errors++; $display("FAIL bp_hold: cycle %0d got valid=%b data=%h want 1 %h", i, v_valid, v_data, 40'h00_0002_0000);
            end
            idle(1);
        end
        checks++; if (got_data.size() != 0) begin errors++; $display("FAIL bp_nothing_sent: got %0d results want 0", got_data.size()); end
        m_tready = 1'b1;
        #1;
        checks++; if (v_tready !== 1'b1) begin errors++; $display("FAIL bp_s_tready_comb: got %b want 1", v_tready); end
        wait_results(2, 20);
        idle(5);
        checks++; if (got_data.size() != 2) begin errors++; $display("FAIL bp_count: got %0d results want 2", got_data.size()); end
        if (got_data.size() == 2) begin
            for (int i = 0; i < 2; i++) begin
                checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL bp_sum%0d: got %h want %h", i, got_data[i], exp_q[i]); end
            end
            checks++; if (got_id[1] !== 8'h22) begin errors++; $display("FAIL bp_tid: got %h want 22", got_id[1]); end
        end
        checks++; if (v_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got tvalid %b want 0", v_valid); end
    endtask

    task automatic test_reset_mid_frame();
        clear_queues();
        sel = 0;
        m_tready = 1'b1;
        send_beat(16'h0100, 16'h0100, 1'b0, 8'h31);
        send_beat(16'h0100, 16'h0100, 1'b0, 8'h32);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++; if (v_tready !== 1'b1) begin errors++; $display("FAIL rstmid_s_tready: got %b want 1", v_tready); end
        checks++; if (v_valid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b want 0", v_valid); end
        idle(5);
        checks++; if (got_data.size() != 0) begin errors++; $display("FAIL rstmid_no_output: got %0d results want 0", got_data.size()); end
        exp_q.push_back(40'h00_0001_0000);
        send_beat(16'h0100, 16'h0100, 1'b1, 8'h33);
        wait_results(1, 20);
        idle(3);
        checks++; if (got_data.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d results want 1", got_data.size()); end
        if (got_data.size() == 1) begin
            checks++; if (got_data[0] !== exp_q[0]) begin errors++; $display("FAIL rstmid_sum: got %h want %h", got_data[0], exp_q[0]); end
        end
    endtask

    task automatic test_overflow_w32();
        clear_queues();
        sel = 1;
        m_tready = 1'b1;
        // (-1.0 * 2^7)^2 = 2^30 per beat; 3 beats wrap to 0xC000_0000 in 32 bits
        exp_q.push_back(40'h00_C000_0000);
        exp_q.push_back(40'h00_0001_0000);
        for (int i = 0; i < 3; i++) send_beat(16'h8000, 16'h8000, (i == 2), 8'h55);
        send_beat(16'h0100, 16'h0100, 1'b1, 8'h66);
        wait_results(2, 20);
        idle(3);
        checks++; if (got_data.size() != 2) begin errors++; $display("FAIL ovf_count: got %0d results want 2", got_data.size()); end
        if (got_data.size() == 2) begin
            checks++; if (got_data[0] !== exp_q[0]) begin errors++; $display("FAIL ovf_sum: got %h want %h", got_data[0], exp_q[0]); end
            checks++; if (got_user[0] !== 1'b1) begin errors++; $display("FAIL ovf_tuser: got %b want 1", got_user[0]); end
            checks++; if (got_data[1] !== exp_q[1]) begin errors++; $display("FAIL ovf_next_sum: got %h want %h", got_data[1], exp_q[1]); end
            checks++; if (got_user[1] !== 1'b0) begin errors++; $display("FAIL ovf_next_tuser: got %b want 0", got_user[1]); end
            checks++; if (got_id[0] !== 8'h00) begin errors++; $display("FAIL ovf_tid_disabled: got %h want 00", got_id[0]); end
        end
    endtask

    task automatic test_unsigned();
        clear_queues();
        sel = 2;
        m_tready = 1'b1;
        exp_q.push_back(40'h00_FFFE_0001);
        send_beat(16'hFFFF, 16'hFFFF, 1'b1, 8'h77);
        wait_results(1, 20);
        idle(3);
        checks++; if (got_data.size() != 1) begin errors++; $display("FAIL uns_count: got %0d results want 1", got_data.size()); end
        if (got_data.size() == 1) begin
            checks++; if (got_data[0] !== exp_q[0]) begin errors++; $display("FAIL uns_sum: got %h want %h", got_data[0], exp_q[0]); end
            checks++; if (got_user[0] !== 1'b0) begin errors++; $display("FAIL uns_tuser: got %b want 0", got_user[0]); end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        stall_cycles = 0;
        sel          = 0;
        rst          = 1'b1;
        s_tdata      = '0;
        s_tvalid     = 1'b0;
        s_tlast      = 1'b0;
        s_tid        = '0;
        m_tready     = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_frame_sum();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        test_overflow_w32();
        test_unsigned();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
